// File: rtl/bram_result_drainer.sv
// Drains a run of 64-bit BRAM1 words onto a 16-bit valid/ready stream,
// most-significant lane first, with one fetch/wait pair per word.
module bram_result_drainer #(
    parameter int unsigned CNT_BIT   = 31,
    parameter int unsigned DWIDTH_2  = 64,
    parameter int unsigned AWIDTH    = 8,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_drain_i,
    input  logic [CNT_BIT-1:0]   drain_count_i,
    output logic [AWIDTH-1:0]    addr_b1_o,
    output logic                 ce_b1_o,
    output logic                 we_b1_o,
    input  logic [DWIDTH_2-1:0]  q_b1_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [OUT_WIDTH-1:0] m_data_o,
    output logic                 m_last_o,
    output logic                 idle_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StSend, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_BIT-1:0]   count_q, count_d;
    logic [CNT_BIT-1:0]   word_idx_q, word_idx_d;
    logic [1:0]           lane_idx_q, lane_idx_d;
    logic [DWIDTH_2-1:0]  buf_q, buf_d;
    logic [1:0]           lane_sel;
    logic [OUT_WIDTH-1:0] lane_data;
    logic                 last_word;

    // Lane 0 is the most-significant slice of the buffered word.
    assign lane_sel  = 2'd3 - lane_idx_q;
    assign lane_data = buf_q[int'(lane_sel)*OUT_WIDTH +: OUT_WIDTH];
    assign last_word = (word_idx_q == count_q - CNT_BIT'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            word_idx_q <= '0;
            lane_idx_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            lane_idx_q <= lane_idx_d;
            buf_q      <= buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        lane_idx_d = lane_idx_q;
        buf_d      = buf_q;
        unique case (state_q)
            StIdle: begin
                if (start_drain_i) begin
                    count_d    = drain_count_i;
                    word_idx_d = '0;
                    lane_idx_d = '0;
                    state_d    = (drain_count_i == '0) ? StDone : StFetch;
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                buf_d   = q_b1_i;
                state_d = StSend;
            end
            StSend: begin
                if (m_ready_i) begin
                    lane_idx_d = lane_idx_q + 2'd1;
                    if (lane_idx_q == 2'd3) begin
                        if (last_word) begin
                            state_d = StDone;
                        end else begin
                            word_idx_d = word_idx_q + CNT_BIT'(1);
                            lane_idx_d = '0;
                            state_d    = StFetch;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ce_b1_o   = (state_q == StFetch);
        addr_b1_o = (state_q == StFetch) ? word_idx_q[AWIDTH-1:0] : '0;
        we_b1_o   = 1'b0;
        m_valid_o = (state_q == StSend);
        m_data_o  = (state_q == StSend) ? lane_data : '0;
        m_last_o  = (state_q == StSend) && (lane_idx_q == 2'd3) && last_word;
        idle_o    = (state_q == StIdle);
        busy_o    = (state_q == StFetch) || (state_q == StWait) || (state_q == StSend);
        done_o    = (state_q == StDone);
    end

endmodule

// File: doc/bram_result_drainer.md
BRAM_RESULT_DRAINER -- requirements
Module: bram_result_drainer

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- CNT_BIT, 31, width of the word-count input.
- DWIDTH_2, 64, BRAM1 word width.
- AWIDTH, 8, BRAM1 address width.
- OUT_WIDTH, 16, stream lane width; DWIDTH_2 = 4*OUT_WIDTH.

REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.

REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- start_drain_i, in, 1, start pulse; sampled only in IDLE.
- drain_count_i, in, CNT_BIT, number of BRAM1 words to drain.
- addr_b1_o, out, AWIDTH, BRAM1 read address.
- ce_b1_o, out, 1, BRAM1 chip enable.
- we_b1_o, out, 1, BRAM1 write enable; constant 0.
- q_b1_i, in, DWIDTH_2, BRAM1 read data; valid exactly 1 cycle after ce_b1_o.
- m_valid_o, out, 1, stream data valid.
- m_ready_i, in, 1, stream sink ready.
- m_data_o, out, OUT_WIDTH, stream lane data.
- m_last_o, out, 1, marks the final lane of the final word.
- idle_o, out, 1, high in IDLE.
- busy_o, out, 1, high in FETCH, WAIT or SEND.
- done_o, out, 1, one-cycle pulse in DONE.

Function
REQ-004 The state machine SHALL have the states IDLE, FETCH, WAIT, SEND and DONE; all outputs are driven from state and registers only.

REQ-005 In IDLE with start_drain_i=1, the block SHALL latch drain_count_i, clear word_idx and lane_idx, and go to FETCH, or to DONE if the count is 0.

REQ-006 FETCH SHALL last 1 cycle: ce_b1_o=1 and addr_b1_o=word_idx[AWIDTH-1:0], then go to WAIT; ce_b1_o SHALL be 0 in every other state.

REQ-007 WAIT SHALL last 1 cycle: capture q_b1_i into a DWIDTH_2 word buffer, then go to SEND.

REQ-008 In SEND, m_valid_o SHALL be 1 and m_data_o SHALL be the buffer lane selected by lane_idx, in this order:
- lane 0 = [63:48]
- lane 1 = [47:32]
- lane 2 = [31:16]
- lane 3 = [15:0]

REQ-009 A beat SHALL transfer only on a cycle where m_valid_o=1 and m_ready_i=1; lane_idx SHALL increment on each transfer.

REQ-010 While m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o SHALL hold stable and the state SHALL not change.

REQ-011 On the lane-3 transfer:
- if word_idx = count-1, the block SHALL go to DONE;
- otherwise it SHALL increment word_idx, reset lane_idx to 0 and go to FETCH.

REQ-012 m_last_o SHALL be 1 only in SEND with lane_idx=3 and word_idx=count-1.

REQ-013 DONE SHALL last 1 cycle with done_o=1, then return to IDLE.

REQ-014 start_drain_i outside IDLE SHALL be ignored, and the latched count SHALL be unchanged.

REQ-015 addr_b1_o SHALL wrap modulo 2^AWIDTH when the count exceeds 2^AWIDTH; word_idx and the count compare SHALL use the full CNT_BIT width.

REQ-016 Per word, the minimum latency SHALL be 6 cycles (FETCH, WAIT, then 4 SEND beats) with m_ready_i held at 1; the first m_valid_o SHALL rise 3 cycles after the start edge.

Reset
REQ-017 While reset=1, asynchronously and regardless of clk:
- state = IDLE;
- word_idx, lane_idx, the latched count and the buffer = 0;
- m_valid_o, m_last_o, ce_b1_o, we_b1_o, busy_o and done_o = 0; addr_b1_o and m_data_o = 0;
- idle_o = 1.

REQ-018 Reset asserted mid-drain SHALL abort the drain with no done_o pulse; after reset, the block SHALL accept a new start.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single word: BRAM1[0]=0x0001_0003_0005_0007, count=1, m_ready_i=1 -> beats 0x0001, 0x0003, 0x0005, 0x0007; m_last_o on the 4th beat; done_o 1 cycle later; ce_b1_o asserted once with addr 0.
- Full drain: BRAM1[i]={4{i[15:0]}}, count=256, ready=1 -> 1024 beats in address order 0..255; total 1536 busy cycles; single done_o pulse.
- Backpressure: count=2, m_ready_i toggled 1,0,0,1,... -> no beat lost or duplicated; m_data_o stable during ready=0; 8 beats in order.
- Zero count: start with count=0 -> IDLE, DONE, IDLE; no ce_b1_o, no m_valid_o; done_o high exactly 1 cycle.
- Wrap and ignored start: count=258 -> addresses 255, 0, 1 for words 255..257; a start pulse during SEND is ignored.
- Mid-run reset: reset=1 during the 3rd word -> all outputs reach reset values in the same cycle; no done_o; a new start with count=1 completes normally.
